// File: rtl/regfile_mp.sv
// regfile_mp: clocked multi-port register file.
// Three combinational read ports with optional same-cycle write forwarding,
// two prioritised write ports (w1 beats w0), a per-register pending
// scoreboard for multi-cycle producers, and a handshaked serial dump port
// that walks the whole array for the debug/display path.

module regfile_mp #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter bit                ZERO_REG = 1'b1,
    parameter bit                BYPASS   = 1'b1,
    parameter int                INIT_IDX = 8,
    parameter logic [DATA_W-1:0] INIT_VAL = '1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    input  logic [ADDR_W-1:0] rc_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic [DATA_W-1:0] rc_data,
    output logic              ra_busy,
    output logic              rb_busy,
    output logic              rc_busy,

    input  logic              w0_en,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    input  logic              w1_en,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,

    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,

    input  logic              dump_req,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    localparam int                N        = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

    typedef enum logic {
        DUMP_IDLE,
        DUMP_RUN
    } dumpState_e;

    // Storage and scoreboard
    logic [DATA_W-1:0] regs_q [N];
    logic [DATA_W-1:0] regs_d [N];
    logic [N-1:0]      pend_q;
    logic [N-1:0]      pend_d;

    // Qualified write / mark requests (address 0 filtered when hardwired)
    logic w0Apply;
    logic w1Apply;
    logic pendApply;

    // Read ports gathered into vectors so one loop serves all three
    logic [2:0][ADDR_W-1:0] readAddr;
    logic [2:0][DATA_W-1:0] readData;
    logic [2:0]             readBusy;

    // Dump FSM state
    dumpState_e        state_q;
    dumpState_e        state_d;
    logic [ADDR_W-1:0] dumpIdx_q;
    logic [ADDR_W-1:0] dumpIdx_d;
    logic              dumpDone_q;
    logic              dumpDone_d;

    assign w0Apply   = w0_en    && !(ZERO_REG && (w0_addr   == '0));
    assign w1Apply   = w1_en    && !(ZERO_REG && (w1_addr   == '0));
    assign pendApply = pend_set && !(ZERO_REG && (pend_addr == '0));

    assign readAddr[0] = ra_addr;
    assign readAddr[1] = rb_addr;
    assign readAddr[2] = rc_addr;

    assign ra_data = readData[0];
    assign rb_data = readData[1];
    assign rc_data = readData[2];
    assign ra_busy = readBusy[0];
    assign rb_busy = readBusy[1];
    assign rc_busy = readBusy[2];

    // Next array contents: w1 is applied after w0 so it wins on a collision
    always_comb begin
        for (int i = 0; i < N; i++) begin
            regs_d[i] = regs_q[i];
            if (w0Apply && (w0_addr == ADDR_W'(i))) begin
                regs_d[i] = w0_data;
            end
            if (w1Apply && (w1_addr == ADDR_W'(i))) begin
                regs_d[i] = w1_data;
            end
        end
    end

    // Array register; one entry carries a non-zero reset value unless it is the hardwired zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                if ((i == INIT_IDX) && !(ZERO_REG && (INIT_IDX == 0))) begin
                    regs_q[i] <= INIT_VAL;
                end else begin
                    regs_q[i] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Next pending bits: a write clears its register, a mark applied in the same cycle takes priority
    always_comb begin
        for (int i = 0; i < N; i++) begin
            pend_d[i] = pend_q[i];
            if ((w0Apply && (w0_addr == ADDR_W'(i))) ||
                (w1Apply && (w1_addr == ADDR_W'(i)))) begin
                pend_d[i] = 1'b0;
            end
            if (pendApply && (pend_addr == ADDR_W'(i))) begin
                pend_d[i] = 1'b1;
            end
        end
    end

    // Pending scoreboard register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Read ports: array value, optionally overridden by same-cycle writes (w1 last so it wins), then zero-forcing
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            readData[p] = regs_q[readAddr[p]];
            if (BYPASS) begin
                if (w0Apply && (w0_addr == readAddr[p])) begin
                    readData[p] = w0_data;
                end
                if (w1Apply && (w1_addr == readAddr[p])) begin
                    readData[p] = w1_data;
                end
            end
            if (ZERO_REG && (readAddr[p] == '0)) begin
                readData[p] = '0;
            end
            readBusy[p] = pend_q[readAddr[p]];
        end
    end

    // Dump FSM state register; reset aborts any dump silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= DUMP_IDLE;
            dumpIdx_q  <= '0;
            dumpDone_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dumpIdx_q  <= dumpIdx_d;
            dumpDone_q <= dumpDone_d;
        end
    end

    // Dump FSM next state: advance on each accepted beat, wrap to idle after the last
    always_comb begin
        state_d    = state_q;
        dumpIdx_d  = dumpIdx_q;
        dumpDone_d = 1'b0;
        case (state_q)
            DUMP_IDLE: begin
                if (dump_req) begin
                    state_d   = DUMP_RUN;
                    dumpIdx_d = '0;
                end
            end
            DUMP_RUN: begin
                if (dump_ready) begin
                    if (dumpIdx_q == LAST_IDX) begin
                        state_d    = DUMP_IDLE;
                        dumpIdx_d  = '0;
                        dumpDone_d = 1'b1;
                    end else begin
                        dumpIdx_d = dumpIdx_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d   = DUMP_IDLE;
                dumpIdx_d = '0;
            end
        endcase
    end

    // Dump FSM outputs: beat data follows the live array so a stalled beat sees later writes
    always_comb begin
        dump_valid = (state_q == DUMP_RUN);
        dump_idx   = dumpIdx_q;
        dump_done  = dumpDone_q;
        dump_data  = regs_q[dumpIdx_q];
        if (ZERO_REG && (dumpIdx_q == '0)) begin
            dump_data = '0;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp.
// The stimulus process drives one cycle at a time, predicts every output
// from an array-level model and queues the prediction; an independent
// monitor pops and compares each cycle, and pops expected dump beats only
// when the DUT itself shows a handshake.

module tb_regfile_mp;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] ra_addr = '0, rb_addr = '0, rc_addr = '0;
    logic [DW-1:0] ra_data, rb_data, rc_data;
    logic          ra_busy, rb_busy, rc_busy;
    logic          w0_en = 1'b0, w1_en = 1'b0;
    logic [AW-1:0] w0_addr = '0, w1_addr = '0;
    logic [DW-1:0] w0_data = '0, w1_data = '0;
    logic          pend_set = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    logic          dump_req = 1'b0, dump_ready = 1'b0;
    logic          dump_valid;
    logic [AW-1:0] dump_idx;
    logic [DW-1:0] dump_data;
    logic          dump_done;

    regfile_mp dut (
        .clk(clk), .rst(rst),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
        .ra_data(ra_data), .rb_data(rb_data), .rc_data(rc_data),
        .ra_busy(ra_busy), .rb_busy(rb_busy), .rc_busy(rc_busy),
        .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
        .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
        .pend_set(pend_set), .pend_addr(pend_addr),
        .dump_req(dump_req), .dump_ready(dump_ready),
        .dump_valid(dump_valid), .dump_idx(dump_idx),
        .dump_data(dump_data), .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [AW-1:0] ra, rb, rc;
        logic          w0En, w1En;
        logic [AW-1:0] w0Addr, w1Addr;
        logic [DW-1:0] w0Data, w1Data;
        logic          pendSet;
        logic [AW-1:0] pendAddr;
        logic          dumpReq, dumpReady;
    } stim_t;

    typedef struct {
        logic [DW-1:0] ra, rb, rc;
        logic [2:0]    busy;
        logic          valid;
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
        logic          done;
    } exp_t;

    typedef struct {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } beat_t;

    exp_t  cycQ[$];
    beat_t beatQ[$];

    int vectors    = 0;
    int miscompares = 0;
    int dutBeats   = 0;
    int doneCount  = 0;

    // Reference model: plain arrays plus a "dump in progress" cursor
    logic [DW-1:0] mem [N];
    bit            pend [N];
    bit            dumping;
    int            dIdx;
    bit            doneFlag;

    stim_t s;
    int    cyc;
    int    beatsBefore;
    int    doneBefore;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idleStim();
        stim_t t;
        t.rst = 1'b0; t.ra = '0; t.rb = '0; t.rc = '0;
        t.w0En = 1'b0; t.w1En = 1'b0; t.w0Addr = '0; t.w1Addr = '0;
        t.w0Data = '0; t.w1Data = '0; t.pendSet = 1'b0; t.pendAddr = '0;
        t.dumpReq = 1'b0; t.dumpReady = 1'b0;
        return t;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < N; i++) begin
            mem[i]  = (i == 8) ? 32'hFFFF_FFFF : 32'h0;
            pend[i] = 1'b0;
        end
        dumping  = 1'b0;
        dIdx     = 0;
        doneFlag = 1'b0;
    endfunction

    function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] a, input stim_t t);
        if (a == 0) return '0;
        if (t.w1En && t.w1Addr == a) return t.w1Data;
        if (t.w0En && t.w0Addr == a) return t.w0Data;
        return mem[a];
    endfunction

    function automatic logic [DW-1:0] modelDump(input int i);
        return (i == 0) ? '0 : mem[i];
    endfunction

    // Advance the model across one rising edge
    function automatic void modelStep(input stim_t t);
        bit    hs;
        beat_t b;
        hs = dumping && t.dumpReady;
        if (hs) begin
            b.idx  = AW'(dIdx);
            b.data = modelDump(dIdx);
            beatQ.push_back(b);
        end
        if (t.w0En && t.w0Addr != 0) mem[t.w0Addr] = t.w0Data;
        if (t.w1En && t.w1Addr != 0) mem[t.w1Addr] = t.w1Data;
        if (t.w0En) pend[t.w0Addr] = 1'b0;
        if (t.w1En) pend[t.w1Addr] = 1'b0;
        if (t.pendSet && t.pendAddr != 0) pend[t.pendAddr] = 1'b1;
        doneFlag = hs && (dIdx == N - 1);
        if (dumping) begin
            if (hs) begin
                if (dIdx == N - 1) begin
                    dumping = 1'b0;
                    dIdx    = 0;
                end else begin
                    dIdx++;
                end
            end
        end else if (t.dumpReq) begin
            dumping = 1'b1;
            dIdx    = 0;
        end
    endfunction

    task automatic applyStimulus(input stim_t t);
        exp_t e;
        @(negedge clk);
        rst = t.rst;
        ra_addr = t.ra; rb_addr = t.rb; rc_addr = t.rc;
        w0_en = t.w0En; w0_addr = t.w0Addr; w0_data = t.w0Data;
        w1_en = t.w1En; w1_addr = t.w1Addr; w1_data = t.w1Data;
        pend_set = t.pendSet; pend_addr = t.pendAddr;
        dump_req = t.dumpReq; dump_ready = t.dumpReady;
        #1;
        if (t.rst) modelReset();
        e.ra    = modelRead(t.ra, t);
        e.rb    = modelRead(t.rb, t);
        e.rc    = modelRead(t.rc, t);
        e.busy  = {pend[t.rc], pend[t.rb], pend[t.ra]};
        e.valid = dumping;
        e.idx   = dumping ? AW'(dIdx) : '0;
        e.data  = modelDump(dIdx);
        e.done  = doneFlag;
        cycQ.push_back(e);
        if (!t.rst) modelStep(t);
    endtask

    // Monitor: compares per-cycle outputs and consumes dump beats on real handshakes
    initial begin
        exp_t  e;
        beat_t b;
        forever begin
            @(negedge clk);
            #2;
            if (cycQ.size() > 0) begin
                e = cycQ.pop_front();
                checkOutput("ra_data", ra_data, e.ra);
                checkOutput("rb_data", rb_data, e.rb);
                checkOutput("rc_data", rc_data, e.rc);
                checkOutput("busy", {29'd0, rc_busy, rb_busy, ra_busy}, {29'd0, e.busy});
                checkOutput("dump_valid", {31'd0, dump_valid}, {31'd0, e.valid});
                checkOutput("dump_idx", {27'd0, dump_idx}, {27'd0, e.idx});
                checkOutput("dump_done", {31'd0, dump_done}, {31'd0, e.done});
                if (e.valid) checkOutput("dump_data", dump_data, e.data);
            end
            if (dump_done === 1'b1) doneCount++;
            if (dump_valid === 1'b1 && dump_ready === 1'b1) begin
                dutBeats++;
                if (beatQ.size() == 0) begin
                    checkOutput("unexpected_beat", {27'd0, dump_idx}, '1);
                end else begin
                    b = beatQ.pop_front();
                    checkOutput("beat_idx", {27'd0, dump_idx}, {27'd0, b.idx});
                    checkOutput("beat_data", dump_data, b.data);
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        modelReset();

        // Reset contents on all 32 addresses, rst held
        for (int i = 0; i < 11; i++) begin
            s = idleStim();
            s.rst = 1'b1;
            s.ra = AW'(i); s.rb = AW'(i + 11); s.rc = AW'((i + 22) % N);
            applyStimulus(s);
        end
        s = idleStim();
        applyStimulus(s);

        // Dual write to r5: w1 wins, forwarded and stored
        s = idleStim();
        s.w0En = 1; s.w0Addr = 5; s.w0Data = 32'h1111_1111;
        s.w1En = 1; s.w1Addr = 5; s.w1Data = 32'h2222_2222;
        s.ra = 5;
        applyStimulus(s);
        s = idleStim(); s.ra = 5;
        applyStimulus(s);

        // Zero register ignores writes even under bypass; r3 forwards
        s = idleStim(); s.ra = 0;
        applyStimulus(s);
        s = idleStim();
        s.w0En = 1; s.w0Addr = 0; s.w0Data = 32'hDEAD_BEEF; s.ra = 0;
        s.w1En = 1; s.w1Addr = 3; s.w1Data = 32'hA5A5_A5A5; s.rb = 3;
        applyStimulus(s);
        s = idleStim(); s.ra = 0; s.rb = 3;
        applyStimulus(s);

        // Scoreboard: set, set-beats-clear, then a lone w1 write clears
        s = idleStim(); s.pendSet = 1; s.pendAddr = 7; s.rc = 7;
        applyStimulus(s);
        s = idleStim(); s.w0En = 1; s.w0Addr = 7; s.w0Data = 32'h77;
        s.pendSet = 1; s.pendAddr = 7; s.rc = 7;
        applyStimulus(s);
        s = idleStim(); s.rc = 7;
        applyStimulus(s);
        s = idleStim(); s.w1En = 1; s.w1Addr = 7; s.w1Data = 32'h777; s.rc = 7;
        applyStimulus(s);
        s = idleStim(); s.rc = 7; s.pendSet = 1; s.pendAddr = 0;
        applyStimulus(s);
        s = idleStim(); s.ra = 0; s.rc = 7;
        applyStimulus(s);

        // Preload r1..r31 with their own index
        for (int i = 1; i < N; i += 2) begin
            s = idleStim();
            s.w0En = 1; s.w0Addr = AW'(i); s.w0Data = DW'(i);
            if (i + 1 < N) begin
                s.w1En = 1; s.w1Addr = AW'(i + 1); s.w1Data = DW'(i + 1);
            end
            applyStimulus(s);
        end

        // Full dump with ready toggling 1/0
        beatsBefore = dutBeats;
        doneBefore  = doneCount;
        s = idleStim(); s.dumpReq = 1;
        applyStimulus(s);
        cyc = 0;
        while (dumping && cyc < 200) begin
            s = idleStim(); s.dumpReady = (cyc % 2 == 0);
            applyStimulus(s);
            cyc++;
        end
        for (int i = 0; i < 2; i++) begin
            s = idleStim();
            applyStimulus(s);
        end
        #2;
        checkOutput("dump_beats", dutBeats - beatsBefore, 32);
        checkOutput("dump_done_pulses", doneCount - doneBefore, 1);

        // Reset at beat 10 aborts the dump without a done pulse
        doneBefore = doneCount;
        s = idleStim(); s.dumpReq = 1;
        applyStimulus(s);
        cyc = 0;
        while (dIdx < 10 && cyc < 50) begin
            s = idleStim(); s.dumpReady = 1;
            applyStimulus(s);
            cyc++;
        end
        for (int i = 0; i < 2; i++) begin
            s = idleStim(); s.rst = 1; s.dumpReady = 1;
            applyStimulus(s);
        end
        for (int i = 0; i < 2; i++) begin
            s = idleStim(); s.dumpReady = 1;
            applyStimulus(s);
        end
        #2;
        checkOutput("done_after_reset", doneCount - doneBefore, 0);

        // Fresh dump restarts at index 0 with reset contents
        beatsBefore = dutBeats;
        s = idleStim(); s.dumpReq = 1; s.dumpReady = 1;
        applyStimulus(s);
        cyc = 0;
        while (dumping && cyc < 100) begin
            s = idleStim(); s.dumpReady = 1;
            applyStimulus(s);
            cyc++;
        end
        s = idleStim();
        applyStimulus(s);
        #2;
        checkOutput("fresh_dump_beats", dutBeats - beatsBefore, 32);

        // Randomised traffic, including dumps, collisions and occasional reset
        for (int i = 0; i < 1500; i++) begin
            s = idleStim();
            s.rst       = ($urandom_range(0, 299) == 0);
            s.ra        = AW'($urandom_range(0, N - 1));
            s.rb        = AW'($urandom_range(0, N - 1));
            s.rc        = AW'($urandom_range(0, N - 1));
            s.w0En      = $urandom_range(0, 1);
            s.w1En      = $urandom_range(0, 1);
            s.w0Addr    = AW'($urandom_range(0, N - 1));
            s.w1Addr    = ($urandom_range(0, 3) == 0) ? s.w0Addr : AW'($urandom_range(0, N - 1));
            s.w0Data    = $urandom;
            s.w1Data    = $urandom;
            s.pendSet   = $urandom_range(0, 1);
            s.pendAddr  = ($urandom_range(0, 3) == 0) ? s.w0Addr : AW'($urandom_range(0, N - 1));
            s.dumpReq   = ($urandom_range(0, 19) == 0);
            s.dumpReady = $urandom_range(0, 1);
            if (s.ra == s.w0Addr || $urandom_range(0, 1) == 0) s.ra = s.w1Addr;
            applyStimulus(s);
        end

        for (int i = 0; i < 2; i++) begin
            s = idleStim();
            applyStimulus(s);
        end
        #2;
        checkOutput("beat_queue_drained", beatQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
